// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run/halt/step sequencer that gates the commit enable of the single-cycle core,
// with a PC breakpoint and a retired-instruction counter.
//
// state  | meaning
// S_INIT | core held in reset for RST_CYCLES cycles, counters cleared
// S_HALT | core frozen, waiting for a run or step request
// S_RUN  | core commits every cycle until halt, breakpoint or soft reset
// S_STEP | exactly one committed instruction, then back to S_HALT
module core_run_ctrl #(
  parameter int PC_W       = 5,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 4,
  parameter int AUTO_RUN   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             soft_rst,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             core_rst,
  output logic             commit_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int INIT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    S_INIT = 2'b00,
    S_HALT = 2'b01,
    S_RUN  = 2'b10,
    S_STEP = 2'b11
  } state_t;

  state_t state_q;
  state_t state_d;

  logic              run_q;
  logic              halt_q;
  logic              step_q;
  logic              soft_q;
  logic [INIT_W-1:0] init_cnt_q;
  logic [CNT_W-1:0]  instr_cnt_q;
  logic              bp_hit_q;
  logic              skip_bp_q;

  logic run_rise;
  logic halt_rise;
  logic step_rise;
  logic soft_rise;
  logic init_done;
  logic bp_match;
  logic leave_halt;

  assign run_rise  = run_req  & ~run_q;
  assign halt_rise = halt_req & ~halt_q;
  assign step_rise = step_req & ~step_q;
  assign soft_rise = soft_rst & ~soft_q;

  assign init_done = (init_cnt_q == INIT_LAST);

  // skip_bp lets the instruction parked on the breakpoint retire once after resuming
  assign bp_match   = (state_q == S_RUN) & bp_en & (pc == bp_addr) & ~skip_bp_q;
  assign leave_halt = (state_q == S_HALT) & (state_d != S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (soft_rise) begin
      state_d = S_INIT;
    end else begin
      case (state_q)
        S_INIT: begin
          if (init_done) begin
            state_d = (AUTO_RUN != 0) ? S_RUN : S_HALT;
          end
        end
        S_HALT: begin
          // a halt edge outranks step/run and swallows them
          if (!halt_rise) begin
            if (step_rise) begin
              state_d = S_STEP;
            end else if (run_rise) begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bp_match || halt_rise) begin
            state_d = S_HALT;
          end
        end
        S_STEP: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_INIT;
        end
      endcase
    end
  end

  always_comb begin
    core_rst  = 1'b0;
    commit_en = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_INIT: core_rst  = 1'b1;
      S_HALT: halted    = 1'b1;
      S_RUN:  commit_en = ~bp_match & ~soft_rise;
      S_STEP: commit_en = ~soft_rise;
      default: begin
        core_rst = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      halt_q <= 1'b0;
      step_q <= 1'b0;
      soft_q <= 1'b0;
    end else begin
      run_q  <= run_req;
      halt_q <= halt_req;
      step_q <= step_req;
      soft_q <= soft_rst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt_q <= '0;
    end else if (soft_rise || state_q != S_INIT || init_done) begin
      init_cnt_q <= '0;
    end else begin
      init_cnt_q <= init_cnt_q + INIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_q <= '0;
    end else if (soft_rise || state_q == S_INIT) begin
      instr_cnt_q <= '0;
    end else if (commit_en) begin
      instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_hit_q  <= 1'b0;
      skip_bp_q <= 1'b0;
    end else if (soft_rise) begin
      bp_hit_q  <= 1'b0;
      skip_bp_q <= 1'b0;
    end else if (leave_halt) begin
      bp_hit_q  <= 1'b0;
      skip_bp_q <= 1'b1;
    end else begin
      if (bp_match) begin
        bp_hit_q <= 1'b1;
      end
      if (commit_en) begin
        skip_bp_q <= 1'b0;
      end
    end
  end

  assign state     = state_q;
  assign bp_hit    = bp_hit_q;
  assign instr_cnt = instr_cnt_q;

endmodule
